snes_rom_burst_reader: RTL and testbench
========================================

Name: snes_rom_burst_reader

Overview:
- Parametrised successor to the free-running cartridge address stepper.
- Reads an inclusive address range [start_addr, end_addr] from the SNES cartridge bus.
- Each read has a runtime-programmable wait-state count; the captured byte is presented on a valid/ready stream toward the dump/transport logic.
- Supports start, abort, busy and done control, and an optional running 16-bit ROM checksum.

Parameters:
- ADDR_W, 24, cartridge address width in bits (LoROM/HiROM full 24-bit bus).
- DATA_W, 8, cartridge data width in bits.
- WAIT_W, 4, width of the wait_cycles input.

Ports:
- clk  input  1  system clock; all state updates on the falling edge, matching the existing cartridge readers.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- abort  input  1  terminate the burst; highest priority after reset.
- start_addr  input  ADDR_W  first address read; latched at start.
- end_addr  input  ADDR_W  last address read (inclusive); latched at start.
- wait_cycles  input  WAIT_W  extra clk cycles rd_n is held low before capture; latched at start.
- data  input  DATA_W  cartridge data bus.
- address  output  ADDR_W  cartridge address bus.
- rd_n  output  1  cartridge read strobe, active low.
- out_data  output  DATA_W  captured byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in SETUP and HOLD.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state = IDLE; address = 0; rd_n = 1; out_data = 0; out_valid = 0; busy = 0; done = 0.
  - Internal wait counter = 0; latched end address = 0; latched wait = 0.
- IDLE:
  - rd_n = 1.
  - If start = 1 at an edge: latch end_addr and wait_cycles; load address = start_addr and counter = wait_cycles; drive rd_n = 0; go to SETUP.
- SETUP:
  - address stable, rd_n = 0.
  - If counter != 0: decrement it.
  - If counter = 0: at that edge capture data into out_data, set out_valid = 1, drive rd_n = 1, go to HOLD.
  - The strobe is therefore low for exactly wait_cycles+1 clk cycles; wait_cycles = 0 gives a 1-cycle strobe.
- HOLD:
  - out_valid = 1; out_data and address are held.
  - At an edge with out_ready = 1, the transfer completes and out_valid drops.
    - If address == latched end: go to DONE.
    - Otherwise: address = address+1 (mod 2^ADDR_W), reload counter, drive rd_n = 0, go to SETUP.
  - While out_ready = 0: stay in HOLD indefinitely (backpressure); no bus activity.
- DONE:
  - done = 1 for exactly one cycle; busy = 0; next state is IDLE.
  - start is ignored while in DONE.
- Throughput: one byte per wait_cycles+2 cycles when out_ready is held high.
- Wrap-around: if end_addr < start_addr, address wraps past 2^ADDR_W-1 to 0 and continues until it equals end_addr.
- start_addr == end_addr: exactly one byte is read.
- start asserted while busy or in DONE: ignored; the latched range is unaffected.
- abort = 1 at any edge in SETUP, HOLD or DONE:
  - next state = IDLE; rd_n = 1; out_valid = 0; done is not pulsed.
  - address and out_data hold their last values.
  - abort together with start in IDLE: abort wins and the state stays IDLE.
- reset_n low mid-burst: immediate return to reset values regardless of clk.
- The latched end and wait values are used for the whole burst; changes on the inputs mid-burst have no effect.

Optional Feature:
- Macro SNES_ROM_BURST_CHECKSUM_EN.
- When defined:
  - Adds output checksum [15:0].
  - checksum clears to 0 on reset and when a burst starts.
  - Each accepted byte (out_valid & out_ready) is added modulo 2^16 to the zero-extended out_data.
  - checksum is held after DONE or abort.
- When not defined: no checksum port or logic; all other behaviour is identical.

Test Plan:
- Reset mid-burst: reset_n low while in SETUP -> address = 0, rd_n = 1, out_valid = 0, busy = 0 within the same cycle.
- Range read:
  - Stimulus: start_addr = 0x008000, end_addr = 0x008003, wait_cycles = 2, out_ready = 1.
  - Required: 4 bytes delivered in order; rd_n low for 3 cycles per byte; 4-cycle byte period; done pulses once; busy then falls.
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles in HOLD.
  - Required: out_valid, out_data and address stable; rd_n = 1; no address advance until out_ready = 1.
- Wrap and single-byte:
  - Wrap: start_addr = 0xFFFFFE, end_addr = 0x000001 -> addresses FFFFFE, FFFFFF, 000000, 000001.
  - Single byte: start_addr = end_addr = 0x00FFC0 -> one byte, then done.
- Abort:
  - Stimulus: abort in HOLD of the 2nd byte.
  - Required: IDLE next cycle, out_valid = 0, no done pulse; a new start afterwards runs a full, correct burst.
- Checksum (macro on): bytes 0xFF, 0x01, 0x80, 0x80 -> checksum = 0x0200; a following burst restarts the sum from 0.

Source files
------------

// File: rtl/snes_rom_burst_reader.sv
// ---------------------------------------------------------------------------
// snes_rom_burst_reader
//
// Reads an inclusive address range [start_addr, end_addr] from the SNES
// cartridge bus. Each byte is read with a programmable number of extra wait
// cycles. The captured byte is then offered on a valid/ready stream. All
// state changes on the falling edge of clk, matching the other cartridge
// readers in this codebase.
//
// Optional feature: define SNES_ROM_BURST_CHECKSUM_EN to add a running
// 16-bit sum of every accepted byte on the checksum output.
//
// Ports:
//   clk, reset_n          falling-edge clock, async active-low reset
//   start, abort          begin a burst (IDLE only) / terminate a burst
//   start_addr, end_addr  inclusive range, latched at start
//   wait_cycles           extra strobe-low cycles per read, latched at start
//   data                  cartridge data bus
//   address, rd_n         cartridge address bus and active-low read strobe
//   out_data, out_valid,
//   out_ready             captured-byte stream toward the dump logic
//   busy                  high while a byte is being read or offered
//   done                  one-cycle pulse after the last byte is accepted
//   checksum              running byte sum (only with the macro defined)
// ---------------------------------------------------------------------------
module snes_rom_burst_reader #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [WAIT_W-1:0] wait_cycles,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] address,
    output logic              rd_n,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
`ifdef SNES_ROM_BURST_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] end_lat;
    logic [WAIT_W-1:0] wait_lat;
    logic [WAIT_W-1:0] wait_cnt;

    // NOTE: every register here is written with non-blocking assignments so
    // that all state samples the values from before the edge.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            address   <= '0;
            rd_n      <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            end_lat   <= '0;
            wait_lat  <= '0;
            wait_cnt  <= '0;
`ifdef SNES_ROM_BURST_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else if (abort) begin
            // Abort outranks everything else, including a start in IDLE.
            // address and out_data keep their last values for debug.
            state     <= IDLE;
            rd_n      <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rd_n <= 1'b1;
                    done <= 1'b0;
                    if (start) begin
                        end_lat  <= end_addr;
                        wait_lat <= wait_cycles;
                        address  <= start_addr;
                        wait_cnt <= wait_cycles;
                        rd_n     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
`ifdef SNES_ROM_BURST_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end

                SETUP: begin
                    // The strobe stays low for wait_lat+1 edges in total:
                    // wait_lat decrements, then the capture edge.
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else begin
                        out_data  <= data;
                        out_valid <= 1'b1;
                        rd_n      <= 1'b1;
                        state     <= HOLD;
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef SNES_ROM_BURST_CHECKSUM_EN
                        checksum  <= checksum + 16'(out_data);
`endif
                        if (address == end_lat) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Wraps naturally past the top of the bus.
                            address  <= address + ADDR_W'(1);
                            wait_cnt <= wait_lat;
                            rd_n     <= 1'b0;
                            state    <= SETUP;
                        end
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snes_rom_burst_reader.sv
module tb_snes_rom_burst_reader;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [WAIT_W-1:0] wait_cycles = '0;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] address;
    logic              rd_n;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              done;
`ifdef SNES_ROM_BURST_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Cartridge ROM contents: a fixed table for the checksum scenario,
    // a scrambled function of the address everywhere else.
    function automatic logic [DATA_W-1:0] rom_byte(input logic [ADDR_W-1:0] a);
        case (a)
            24'h001000: return 8'hFF;
            24'h001001: return 8'h01;
            24'h001002: return 8'h80;
            24'h001003: return 8'h80;
            default:    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hA5;
        endcase
    endfunction

    assign data = rom_byte(address);

    snes_rom_burst_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .WAIT_W(WAIT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .wait_cycles(wait_cycles),
        .data       (data),
        .address    (address),
        .rd_n       (rd_n),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef SNES_ROM_BURST_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive garbage on the burst inputs while a burst is running; none of it
    // may disturb the latched range, wait count or state.
    task automatic scramble();
        start       = 1'($urandom_range(0, 1));
        start_addr  = ADDR_W'($urandom);
        end_addr    = ADDR_W'($urandom);
        wait_cycles = WAIT_W'($urandom);
    endtask

    // Runs one burst from a point just after a rising edge (DUT idle).
    // stall < 0: random backpressure per byte, else a fixed stall count.
    // abort_idx >= 0: abort while the byte with that index is being offered.
    task automatic do_burst(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                            input logic [WAIT_W-1:0] w, input int stall, input int abort_idx);
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp_byte;
        int                idx;
        int                n;
`ifdef SNES_ROM_BURST_CHECKSUM_EN
        logic [15:0]       sum;
        sum = '0;
`endif
        addr = sa;
        idx  = 0;
        start_addr  = sa;
        end_addr    = ea;
        wait_cycles = w;
        start       = 1'b1;
        abort       = 1'b0;
        out_ready   = 1'b0;
        while (1) begin
            // Strobe phase: exactly w+1 sampled cycles with rd_n low.
            for (int i = 0; i <= int'(w); i++) begin
                @(posedge clk);
                scramble();
                check("setup_rd_n", rd_n, 1'b0);
                check("setup_addr", address, addr);
                check("setup_valid", out_valid, 1'b0);
                check("setup_busy", busy, 1'b1);
                check("setup_done", done, 1'b0);
            end
            exp_byte = rom_byte(addr);
            n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s <= n; s++) begin
                @(posedge clk);
                scramble();
                check("hold_valid", out_valid, 1'b1);
                check("hold_rd_n", rd_n, 1'b1);
                check("hold_data", out_data, exp_byte);
                check("hold_addr", address, addr);
                check("hold_busy", busy, 1'b1);
                if (idx == abort_idx) begin
                    abort     = 1'b1;
                    out_ready = 1'b0;
                    break;
                end
                out_ready = (s == n);
            end
            if (idx == abort_idx) begin
                @(posedge clk);
                abort     = 1'b0;
                start     = 1'b0;
                out_ready = 1'b0;
                check("abort_valid", out_valid, 1'b0);
                check("abort_rd_n", rd_n, 1'b1);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_addr", address, addr);
                check("abort_data", out_data, exp_byte);
`ifdef SNES_ROM_BURST_CHECKSUM_EN
                check("abort_checksum", checksum, sum);
`endif
                @(posedge clk);
                check("abort_idle_done", done, 1'b0);
                check("abort_idle_rd_n", rd_n, 1'b1);
                return;
            end
`ifdef SNES_ROM_BURST_CHECKSUM_EN
            sum = sum + 16'(exp_byte);
`endif
            if (addr == ea) break;
            addr = addr + ADDR_W'(1);
            idx++;
        end
        @(posedge clk);
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_valid", out_valid, 1'b0);
        check("done_rd_n", rd_n, 1'b1);
        check("done_addr", address, ea);
        out_ready  = 1'b0;
        start      = 1'b1;  // must be ignored in DONE
        start_addr = ADDR_W'($urandom);
        @(posedge clk);
        start = 1'b0;
        check("after_done", done, 1'b0);
        check("after_busy", busy, 1'b0);
        check("after_rd_n", rd_n, 1'b1);
`ifdef SNES_ROM_BURST_CHECKSUM_EN
        check("burst_checksum", checksum, sum);
`endif
    endtask

    initial begin
        logic [ADDR_W-1:0] sa;
        int                len;
        int                ab;

        // Reset values.
        repeat (2) @(posedge clk);
        check("rst_addr", address, 24'h0);
        check("rst_rd_n", rd_n, 1'b1);
        check("rst_data", out_data, 8'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset_n = 1'b1;

        // Plain range read, 3-cycle strobe, 4-cycle byte period.
        do_burst(24'h008000, 24'h008003, 4'd2, 0, -1);
        // Long backpressure on every byte.
        do_burst(24'h004000, 24'h004002, 4'd1, 10, -1);
        // Wrap across the top of the address space.
        do_burst(24'hFFFFFE, 24'h000001, 4'd0, 0, -1);
        // Single byte.
        do_burst(24'h00FFC0, 24'h00FFC0, 4'd3, 0, -1);
        // Abort in the offer of the second byte, then a clean full burst.
        do_burst(24'h002000, 24'h002005, 4'd1, -1, 1);
        do_burst(24'h002000, 24'h002005, 4'd1, -1, -1);

        // abort together with start in IDLE: nothing starts.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_rd_n", rd_n, 1'b1);
        check("abort_start_busy", busy, 1'b0);
        @(posedge clk);
        check("abort_start_idle", busy, 1'b0);

        // Checksum scenario bytes FF 01 80 80, then a fresh burst.
        do_burst(24'h001000, 24'h001003, 4'd0, 0, -1);
`ifdef SNES_ROM_BURST_CHECKSUM_EN
        check("checksum_0200", checksum, 16'h0200);
`endif
        do_burst(24'h001002, 24'h001002, 4'd0, 0, -1);
`ifdef SNES_ROM_BURST_CHECKSUM_EN
        check("checksum_restart", checksum, 16'h0080);
`endif

        // Randomized bursts, some near the wrap point, some aborted.
        for (int b = 0; b < 16; b++) begin
            sa = ADDR_W'($urandom);
            if ($urandom_range(0, 3) == 0) sa = 24'hFFFFFF - ADDR_W'($urandom_range(0, 3));
            len = int'($urandom_range(1, 6));
            ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            do_burst(sa, sa + ADDR_W'(len - 1), WAIT_W'($urandom_range(0, 3)), -1, ab);
        end

        // Asynchronous reset while the strobe is low.
        start_addr  = 24'h123456;
        end_addr    = 24'h123460;
        wait_cycles = 4'd5;
        start       = 1'b1;
        @(posedge clk);
        start = 1'b0;
        check("pre_reset_rd_n", rd_n, 1'b0);
        check("pre_reset_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_addr", address, 24'h0);
        check("midrst_rd_n", rd_n, 1'b1);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", out_data, 8'h0);
        @(posedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        check("post_reset_idle", busy, 1'b0);
        check("post_reset_rd_n", rd_n, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
